// File: rtl/bus_sequencer.sv
// bus_sequencer: multi-cycle control sequencer for the shared 32-bit datapath bus.
// Steps fetch (T0-T2) and execute (T3-T7) for the instruction held in ir. Each
// T-state drives at most one bus source plus the matching load strobes, and
// stalls in memory states until mem_ready (or a timeout sends it to FAULT).
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   run                      start/continue; sampled only at instruction boundaries
//   ir[31:0]                 opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
//   mem_ready                memory completed the current read/write
//   src_en[23:0]             one-hot bus sources R0..R15, MDR, HI, LO, Zhigh, Zlow, PC, InPort, C
//   reg_in[15:0]             register-file load enables
//   pc_in .. inc_pc          load/increment strobes
//   mem_read, mem_write      memory requests
//   alu_op[4:0]              ALU opcode during the ALU T-state, else 0
//   busy, halted, fault      status
module bus_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int LINK_REG     = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [23:0] src_en,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic        mem_write,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  // T-states are numbered consecutively so "advance" is state + 1.
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_T0    = 4'd1;
  localparam logic [3:0] ST_T1    = 4'd2;
  localparam logic [3:0] ST_T2    = 4'd3;
  localparam logic [3:0] ST_T3    = 4'd4;
  localparam logic [3:0] ST_T4    = 4'd5;
  localparam logic [3:0] ST_T5    = 4'd6;
  localparam logic [3:0] ST_T6    = 4'd7;
  localparam logic [3:0] ST_T7    = 4'd8;
  localparam logic [3:0] ST_HALT  = 4'd9;
  localparam logic [3:0] ST_FAULT = 4'd10;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int SRC_MDR = 16;
  localparam int SRC_HI  = 17;
  localparam int SRC_LO  = 18;
  localparam int SRC_ZHI = 19;
  localparam int SRC_ZLO = 20;
  localparam int SRC_PC  = 21;
  localparam int SRC_C   = 23;

  typedef struct packed {
    logic [23:0] src_en;
    logic [15:0] reg_in;
    logic        pc_in;
    logic        ir_in;
    logic        mar_in;
    logic        mdr_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic        inc_pc;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  alu_op;
    logic        busy;
    logic        halted;
    logic        fault;
  } ctrl_t;

  // Final execute T-state of each opcode; single-state ops end in T3.
  function automatic logic [3:0] last_state(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_state = ST_T5;
      OP_LD, OP_ST:                           last_state = ST_T7;
      OP_MUL, OP_DIV:                         last_state = ST_T6;
      OP_JAL:                                 last_state = ST_T4;
      default:                                last_state = ST_T3;
    endcase
  endfunction

  // Opcodes that enter the execute phase (halt and illegal codes do not).
  function automatic logic is_exec_op(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_MUL, OP_DIV,
      OP_JR, OP_JAL, OP_MFHI, OP_MFLO, OP_NOP: is_exec_op = 1'b1;
      default:                                 is_exec_op = 1'b0;
    endcase
  endfunction

  logic [4:0] op_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       mem_wait_s;
  logic       unused_s;
  logic [3:0] state_r, next_state_s;
  logic [7:0] wait_cnt_r, next_cnt_s;
  ctrl_t      ctrl_r, ctrl_s;

  assign op_s     = ir[31:27];
  assign ra_s     = ir[26:23];
  assign rb_s     = ir[22:19];
  assign rc_s     = ir[18:15];
  assign unused_s = ^ir[14:0];

  // States that hold on a memory handshake.
  assign mem_wait_s = (state_r == ST_T1) ||
                      ((state_r == ST_T6) && (op_s == OP_LD)) ||
                      ((state_r == ST_T7) && (op_s == OP_ST));

  // Next-state and wait-counter logic; the counter only survives a waiting cycle.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = 8'd0;
    if (mem_wait_s && !mem_ready) begin
      if (wait_cnt_r == 8'(MEM_WAIT_MAX - 1)) begin
        next_state_s = ST_FAULT;
      end else begin
        next_cnt_s = wait_cnt_r + 8'd1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) next_state_s = ST_T0;
          else     next_state_s = ST_IDLE;
        end
        ST_T0, ST_T1: next_state_s = state_r + 4'd1;
        ST_T2: begin
          if (is_exec_op(op_s))     next_state_s = ST_T3;
          else if (op_s == OP_HALT) next_state_s = ST_HALT;
          else                      next_state_s = ST_FAULT;
        end
        ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
          if (state_r == last_state(op_s)) next_state_s = run ? ST_T0 : ST_IDLE;
          else                             next_state_s = state_r + 4'd1;
        end
        ST_HALT:  next_state_s = ST_HALT;
        ST_FAULT: next_state_s = ST_FAULT;
        default:  next_state_s = ST_FAULT;
      endcase
    end
  end

  // Moore decode of the strobes for the state being entered.
  always_comb begin
    ctrl_s = '0;
    case (next_state_s)
      ST_T0: begin
        ctrl_s.src_en[SRC_PC] = 1'b1;
        ctrl_s.mar_in = 1'b1;
        ctrl_s.inc_pc = 1'b1;
        ctrl_s.z_in   = 1'b1;
      end
      ST_T1: begin
        ctrl_s.src_en[SRC_ZLO] = 1'b1;
        ctrl_s.pc_in    = 1'b1;
        ctrl_s.mem_read = 1'b1;
        ctrl_s.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl_s.src_en[SRC_MDR] = 1'b1;
        ctrl_s.ir_in = 1'b1;
      end
      ST_T3: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST: begin
            ctrl_s.src_en[rb_s] = 1'b1;
            ctrl_s.y_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            ctrl_s.src_en[ra_s] = 1'b1;
            ctrl_s.y_in = 1'b1;
          end
          OP_MFHI: begin
            ctrl_s.src_en[SRC_HI] = 1'b1;
            ctrl_s.reg_in[ra_s]   = 1'b1;
          end
          OP_MFLO: begin
            ctrl_s.src_en[SRC_LO] = 1'b1;
            ctrl_s.reg_in[ra_s]   = 1'b1;
          end
          OP_JR: begin
            ctrl_s.src_en[ra_s] = 1'b1;
            ctrl_s.pc_in = 1'b1;
          end
          OP_JAL: begin
            ctrl_s.src_en[SRC_PC]   = 1'b1;
            ctrl_s.reg_in[LINK_REG] = 1'b1;
          end
          default: ctrl_s.src_en = 24'd0;
        endcase
      end
      ST_T4: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl_s.src_en[rc_s] = 1'b1;
            ctrl_s.alu_op = op_s;
            ctrl_s.z_in   = 1'b1;
          end
          OP_ADDI: begin
            ctrl_s.src_en[SRC_C] = 1'b1;
            ctrl_s.alu_op = op_s;
            ctrl_s.z_in   = 1'b1;
          end
          // Effective address = rb + constant, always computed with add.
          OP_LD, OP_ST: begin
            ctrl_s.src_en[SRC_C] = 1'b1;
            ctrl_s.alu_op = OP_ADD;
            ctrl_s.z_in   = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            ctrl_s.src_en[rb_s] = 1'b1;
            ctrl_s.alu_op = op_s;
            ctrl_s.z_in   = 1'b1;
          end
          OP_JAL: begin
            ctrl_s.src_en[ra_s] = 1'b1;
            ctrl_s.pc_in = 1'b1;
          end
          default: ctrl_s.src_en = 24'd0;
        endcase
      end
      ST_T5: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            ctrl_s.src_en[SRC_ZLO] = 1'b1;
            ctrl_s.reg_in[ra_s]    = 1'b1;
          end
          OP_LD, OP_ST: begin
            ctrl_s.src_en[SRC_ZLO] = 1'b1;
            ctrl_s.mar_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            ctrl_s.src_en[SRC_ZLO] = 1'b1;
            ctrl_s.lo_in = 1'b1;
          end
          default: ctrl_s.src_en = 24'd0;
        endcase
      end
      ST_T6: begin
        case (op_s)
          OP_LD: begin
            ctrl_s.mem_read = 1'b1;
            ctrl_s.mdr_in   = 1'b1;
          end
          OP_ST: begin
            ctrl_s.src_en[ra_s] = 1'b1;
            ctrl_s.mdr_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            ctrl_s.src_en[SRC_ZHI] = 1'b1;
            ctrl_s.hi_in = 1'b1;
          end
          default: ctrl_s.src_en = 24'd0;
        endcase
      end
      ST_T7: begin
        case (op_s)
          OP_LD: begin
            ctrl_s.src_en[SRC_MDR] = 1'b1;
            ctrl_s.reg_in[ra_s]    = 1'b1;
          end
          OP_ST:   ctrl_s.mem_write = 1'b1;
          default: ctrl_s.src_en = 24'd0;
        endcase
      end
      ST_HALT:  ctrl_s.halted = 1'b1;
      ST_FAULT: ctrl_s.fault  = 1'b1;
      default:  ctrl_s.src_en = 24'd0;
    endcase
    if ((next_state_s == ST_IDLE) || (next_state_s == ST_HALT) || (next_state_s == ST_FAULT)) begin
      ctrl_s.busy = 1'b0;
    end else begin
      ctrl_s.busy = 1'b1;
    end
  end

  // State, wait counter and registered strobes; reset clears everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 8'd0;
      ctrl_r     <= '0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= next_cnt_s;
      ctrl_r     <= ctrl_s;
    end
  end

  assign src_en    = ctrl_r.src_en;
  assign reg_in    = ctrl_r.reg_in;
  assign pc_in     = ctrl_r.pc_in;
  assign ir_in     = ctrl_r.ir_in;
  assign mar_in    = ctrl_r.mar_in;
  assign mdr_in    = ctrl_r.mdr_in;
  assign y_in      = ctrl_r.y_in;
  assign z_in      = ctrl_r.z_in;
  assign hi_in     = ctrl_r.hi_in;
  assign lo_in     = ctrl_r.lo_in;
  assign inc_pc    = ctrl_r.inc_pc;
  assign mem_read  = ctrl_r.mem_read;
  assign mem_write = ctrl_r.mem_write;
  assign alu_op    = ctrl_r.alu_op;
  assign busy      = ctrl_r.busy;
  assign halted    = ctrl_r.halted;
  assign fault     = ctrl_r.fault;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: every instruction pushes its expected
// per-cycle output vectors plus the stimulus for that cycle; the executor pops
// one entry per clock and compares the whole output vector.
module tb_bus_sequencer;
  localparam int MW = 15;

  logic        clock = 1'b0;
  logic        reset_n, run, mem_ready;
  logic [31:0] ir;
  logic [23:0] src_en;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc;
  logic        mem_read, mem_write, busy, halted, fault;
  logic [4:0]  alu_op;

  always #5 clock = ~clock;

  bus_sequencer #(.MEM_WAIT_MAX(MW), .LINK_REG(15)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .src_en(src_en), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
    .busy(busy), .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic [23:0] src;
    logic [15:0] rin;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read, mem_write;
    logic [4:0] alu;
    logic busy, halted, fault;
  } exp_t;

  exp_t        exp_q[$];
  logic        rdy_q[$];
  logic        run_q[$];
  logic [31:0] ir_q[$];
  string       tag_q[$];
  exp_t        ex_q[$];
  logic        exr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] observed();
    return {5'd0, src_en, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
            inc_pc, mem_read, mem_write, alu_op, busy, halted, fault};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t mk();
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic push(input exp_t e, input logic rdy, input logic rn, input logic [31:0] i, input string t);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    run_q.push_back(rn);
    ir_q.push_back(i);
    tag_q.push_back(t);
  endtask

  // One execute state: 'stall' cycles with mem_ready low, then one with it high.
  task automatic xq(input exp_t e, input int stall);
    for (int k = 0; k < stall; k++) begin
      ex_q.push_back(e);
      exr_q.push_back(1'b0);
    end
    ex_q.push_back(e);
    exr_q.push_back(1'b1);
  endtask

  task automatic push_hold(input logic [31:0] ins, input logic is_fault);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e = '0;
      if (is_fault) e.fault = 1'b1;
      else          e.halted = 1'b1;
      push(e, rnd(), rnd(), ins, is_fault ? "fault_hold" : "halt_hold");
    end
  endtask

  task automatic push_instr(input logic [31:0] ins, input int t1_st, input int m_st, input logic run_last);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    exp_t e;
    op = ins[31:27]; ra = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
    ex_q.delete();
    exr_q.delete();
    e = mk(); e.src[21] = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
    push(e, rnd(), rnd(), ins, "T0");
    e = mk(); e.src[20] = 1'b1; e.pc_in = 1'b1; e.mem_read = 1'b1; e.mdr_in = 1'b1;
    if (t1_st >= MW) begin
      for (int k = 0; k < MW; k++) push(e, 1'b0, rnd(), ins, "T1_wait");
      push_hold(ins, 1'b1);
      return;
    end
    for (int k = 0; k <= t1_st; k++) push(e, (k == t1_st), rnd(), ins, "T1");
    e = mk(); e.src[16] = 1'b1; e.ir_in = 1'b1;
    push(e, rnd(), rnd(), ins, "T2");
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100: begin
        e = mk(); e.src[rb] = 1'b1; e.y_in = 1'b1; xq(e, 0);
        e = mk(); e.alu = op; e.z_in = 1'b1;
        if (op == 5'b01100) e.src[23] = 1'b1;
        else                e.src[rc] = 1'b1;
        xq(e, 0);
        e = mk(); e.src[20] = 1'b1; e.rin[ra] = 1'b1; xq(e, 0);
      end
      5'b00000, 5'b00010: begin
        e = mk(); e.src[rb] = 1'b1; e.y_in = 1'b1; xq(e, 0);
        e = mk(); e.src[23] = 1'b1; e.alu = 5'b00011; e.z_in = 1'b1; xq(e, 0);
        e = mk(); e.src[20] = 1'b1; e.mar_in = 1'b1; xq(e, 0);
        if (op == 5'b00000) begin
          e = mk(); e.mem_read = 1'b1; e.mdr_in = 1'b1; xq(e, m_st);
          e = mk(); e.src[16] = 1'b1; e.rin[ra] = 1'b1; xq(e, 0);
        end else begin
          e = mk(); e.src[ra] = 1'b1; e.mdr_in = 1'b1; xq(e, 0);
          e = mk(); e.mem_write = 1'b1; xq(e, m_st);
        end
      end
      5'b01111, 5'b10000: begin
        e = mk(); e.src[ra] = 1'b1; e.y_in = 1'b1; xq(e, 0);
        e = mk(); e.src[rb] = 1'b1; e.alu = op; e.z_in = 1'b1; xq(e, 0);
        e = mk(); e.src[20] = 1'b1; e.lo_in = 1'b1; xq(e, 0);
        e = mk(); e.src[19] = 1'b1; e.hi_in = 1'b1; xq(e, 0);
      end
      5'b10111: begin e = mk(); e.src[17] = 1'b1; e.rin[ra] = 1'b1; xq(e, 0); end
      5'b11000: begin e = mk(); e.src[18] = 1'b1; e.rin[ra] = 1'b1; xq(e, 0); end
      5'b10100: begin e = mk(); e.src[ra] = 1'b1; e.pc_in = 1'b1; xq(e, 0); end
      5'b10101: begin
        e = mk(); e.src[21] = 1'b1; e.rin[15] = 1'b1; xq(e, 0);
        e = mk(); e.src[ra] = 1'b1; e.pc_in = 1'b1; xq(e, 0);
      end
      5'b11010: xq(mk(), 0);
      5'b11011: begin push_hold(ins, 1'b0); return; end
      default:  begin push_hold(ins, 1'b1); return; end
    endcase
    for (int k = 0; k < ex_q.size(); k++)
      push(ex_q[k], exr_q[k], (k == ex_q.size() - 1) ? run_last : rnd(), ins, $sformatf("EX%0d", k));
    if (!run_last) begin
      push('0, rnd(), 1'b0, ins, "IDLE");
      push('0, rnd(), 1'b1, ins, "IDLE_go");
    end
  endtask

  // Pop and compare one entry per clock; n < 0 drains the whole queue.
  task automatic drain(input int n);
    int cnt;
    exp_t e;
    string t;
    cnt = 0;
    while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, observed(), {5'd0, e});
      check("src_onehot", 64'($countones(src_en) > 1), 64'd0);
      mem_ready = rdy_q.pop_front();
      run       = run_q.pop_front();
      ir        = ir_q.pop_front();
      cnt++;
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check("reset_async", observed(), 64'd0);
    exp_q.delete(); rdy_q.delete(); run_q.delete(); ir_q.delete(); tag_q.delete();
    run = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    check("reset_held", observed(), 64'd0);
    reset_n = 1'b1;
    run = 1'b1;
  endtask

  logic [4:0] ops [13] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                           5'b01100, 5'b01111, 5'b10000, 5'b10100, 5'b10101, 5'b10111, 5'b11010};

  initial begin
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = 32'd0;
    #3 check("reset_state", observed(), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run = 1'b1;

    // add r3,r2,r1 twice back to back, then stop
    push_instr(32'h19908000, 0, 0, 1'b1);
    push_instr(32'h19908000, 0, 0, 1'b0);
    drain(-1);
    // ld r5, with a 3-cycle memory stall and a fetch stall
    push_instr({5'b00000, 4'd5, 4'd2, 4'd0, 15'd0}, 0, 3, 1'b1);
    push_instr({5'b00000, 4'd9, 4'd4, 4'd0, 15'd0}, 2, 0, 1'b1);
    // jal r6
    push_instr({5'b10101, 4'd6, 23'd0}, 0, 0, 1'b1);
    // st, mul, div, mfhi, mflo, jr, nop, addi, sub, and, or
    push_instr({5'b00010, 4'd7, 4'd3, 4'd0, 15'd0}, 1, 2, 1'b1);
    push_instr({5'b01111, 4'd1, 4'd2, 4'd0, 15'd0}, 0, 0, 1'b0);
    push_instr({5'b10000, 4'd4, 4'd8, 4'd0, 15'd0}, 0, 0, 1'b1);
    push_instr({5'b10111, 4'd0, 23'd0}, 0, 0, 1'b1);
    push_instr({5'b11000, 4'd12, 23'd0}, 0, 0, 1'b1);
    push_instr({5'b10100, 4'd13, 23'd0}, 0, 0, 1'b1);
    push_instr({5'b11010, 27'd0}, 0, 0, 1'b1);
    push_instr({5'b01100, 4'd10, 4'd11, 4'd0, 15'd0}, 0, 0, 1'b1);
    push_instr({5'b00100, 4'd14, 4'd15, 4'd0, 15'd0}, 0, 0, 1'b1);
    push_instr({5'b00101, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 0, 1'b1);
    push_instr({5'b00110, 4'd5, 4'd6, 4'd7, 15'd0}, 0, 0, 1'b1);
    drain(-1);

    // fetch timeout
    push_instr(32'h19908000, 20, 0, 1'b1);
    drain(-1);
    do_reset();
    // illegal opcode
    push_instr({5'b11111, 27'd0}, 0, 0, 1'b1);
    drain(-1);
    do_reset();
    // halt
    push_instr({5'b11011, 27'd0}, 0, 0, 1'b1);
    drain(-1);
    do_reset();

    // random stream with stalls
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31:27] = ops[$urandom_range(0, 12)];
      push_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
      drain(-1);
    end
    // reset while in T4 of an add
    push_instr(32'h19908000, 0, 0, 1'b1);
    drain(5);
    do_reset();
    push_instr({5'b00000, 4'd3, 4'd1, 4'd0, 15'd0}, 1, 1, 1'b0);
    drain(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
